// File: rtl/pixie_pkg.sv
// rtl/pixie_pkg.sv - shared state codes, FSM states and Studio II constants
package pixie_pkg;

  // CDP1802 state codes driven on SC[1:0]
  localparam logic [1:0] SC_FETCH = 2'b00;
  localparam logic [1:0] SC_EXEC  = 2'b01;
  localparam logic [1:0] SC_DMA   = 2'b10;
  localparam logic [1:0] SC_INT   = 2'b11;

  // Studio II display page and row width
  localparam logic [15:0] STUDIO2_VRAM_BASE = 16'h0900;
  localparam int          BYTES_PER_ROW     = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DMA_REQ  = 3'd1,
    ST_DMA_WAIT = 3'd2,
    ST_DMA_END  = 3'd3,
    ST_INT_ACK  = 3'd4
  } pixie_state_e;

endpackage

// File: rtl/pixie_r0_counter.sv
// rtl/pixie_r0_counter.sv - 16-bit R0 register with core load and DMA post-increment
module pixie_r0_counter
  import pixie_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = STUDIO2_VRAM_BASE
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [15:0] load_data,
  input  logic        inc,
  output logic [15:0] r0
);

  // DMA increment beats a core write landing on the same clk; wraps FFFF->0000
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r0 <= RESET_VAL;
    end else if (inc) begin
      r0 <= r0 + 16'd1;
    end else if (load) begin
      r0 <= load_data;
    end
  end

endmodule

// File: rtl/pixie_dma_out_responder.sv
// rtl/pixie_dma_out_responder.sv - CDP1802-side DMA-out and interrupt servicer for the pixie video block
module pixie_dma_out_responder
  import pixie_pkg::*;
#(
  parameter logic [15:0] R0_RESET    = STUDIO2_VRAM_BASE,
  parameter int          BURST_MAX   = BYTES_PER_ROW,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_enable,
  input  logic        cycle_boundary,
  input  logic        dma_out_n,
  input  logic        int_req,
  input  logic        ie,
  input  logic        r0_we,
  input  logic [15:0] r0_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic [1:0]  SC,
  output logic        cpu_stall,
  output logic        int_ack,
  output logic [15:0] r0,
  output logic        bus_err
);

  localparam int BW = $clog2(BURST_MAX + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

  pixie_state_e  state;
  logic [BW-1:0] burst_cnt;
  logic [TW-1:0] timeout_cnt;
  logic          dma_want;
  logic          r0_inc;
  logic          r0_load;

  // A DMA grant needs the request low and room left in the current row burst
  assign dma_want = !dma_out_n && (burst_cnt < BURST_LIM);

  // R0 only moves on a completed fetch; core writes are honoured only while idle
  assign r0_inc  = (state == ST_DMA_WAIT) && mem_ack;
  assign r0_load = (state == ST_IDLE) && r0_we;

  pixie_r0_counter #(
    .RESET_VAL (R0_RESET)
  ) u_r0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (r0_load),
    .load_data (r0_wdata),
    .inc       (r0_inc),
    .r0        (r0)
  );

  // Arbitration FSM; everything steps on clk_enable except the memory ack, taken on any clk
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      mem_addr    <= '0;
      mem_rd      <= 1'b0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      SC          <= SC_FETCH;
      cpu_stall   <= 1'b0;
      int_ack     <= 1'b0;
      bus_err     <= 1'b0;
      burst_cnt   <= '0;
      timeout_cnt <= '0;
    end else begin
      data_valid <= 1'b0;
      int_ack    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (clk_enable) begin
            if (cycle_boundary && dma_want) begin
              state     <= ST_DMA_REQ;
              SC        <= SC_DMA;
              cpu_stall <= 1'b1;
            end else begin
              // any idle tick without a grant is the execute slot that ends a burst
              burst_cnt <= '0;
              if (cycle_boundary && int_req && ie) begin
                state     <= ST_INT_ACK;
                SC        <= SC_INT;
                cpu_stall <= 1'b1;
                int_ack   <= 1'b1;
              end else begin
                SC <= SC_FETCH;
              end
            end
          end
        end
        ST_DMA_REQ: begin
          if (clk_enable) begin
            mem_addr    <= r0;
            mem_rd      <= 1'b1;
            timeout_cnt <= '0;
            state       <= ST_DMA_WAIT;
          end
        end
        ST_DMA_WAIT: begin
          if (mem_ack) begin
            data_out   <= mem_data;
            data_valid <= 1'b1;
            mem_rd     <= 1'b0;
            burst_cnt  <= burst_cnt + 1'b1;
            state      <= ST_DMA_END;
          end else if (clk_enable) begin
            if (timeout_cnt == TO_LAST) begin
              bus_err <= 1'b1;
              mem_rd  <= 1'b0;
              state   <= ST_DMA_END;
            end else begin
              timeout_cnt <= timeout_cnt + 1'b1;
            end
          end
        end
        ST_DMA_END: begin
          if (clk_enable) begin
            if (dma_want) begin
              state <= ST_DMA_REQ;
            end else begin
              state     <= ST_IDLE;
              SC        <= SC_EXEC;
              cpu_stall <= 1'b0;
            end
          end
        end
        ST_INT_ACK: begin
          if (clk_enable) begin
            state     <= ST_IDLE;
            SC        <= SC_FETCH;
            cpu_stall <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixie_dma_out_responder.sv
// tb/tb_pixie_dma_out_responder.sv - self-checking bench for pixie_dma_out_responder
module tb_pixie_dma_out_responder;

  logic        clk;
  logic        reset_n;
  logic        clk_enable;
  logic        cycle_boundary;
  logic        dma_out_n;
  logic        int_req;
  logic        ie;
  logic        r0_we;
  logic [15:0] r0_wdata;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [7:0]  data_out;
  logic        data_valid;
  logic [1:0]  sc;
  logic        cpu_stall;
  logic        int_ack;
  logic [15:0] r0;
  logic        bus_err;

  pixie_dma_out_responder #(
    .R0_RESET    (16'h0900),
    .BURST_MAX   (8),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clk_enable     (clk_enable),
    .cycle_boundary (cycle_boundary),
    .dma_out_n      (dma_out_n),
    .int_req        (int_req),
    .ie             (ie),
    .r0_we          (r0_we),
    .r0_wdata       (r0_wdata),
    .mem_addr       (mem_addr),
    .mem_rd         (mem_rd),
    .mem_ack        (mem_ack),
    .mem_data       (mem_data),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .SC             (sc),
    .cpu_stall      (cpu_stall),
    .int_ack        (int_ack),
    .r0             (r0),
    .bus_err        (bus_err)
  );

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr;
  int          n_checks;
  int          n_pass;
  int          dv_total;
  int          int_total;
  int          run_len;
  int          base;
  int          ibase;
  int          n;
  bit          ack_en;
  bit          ack_rand;
  bit          ce_rand;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_rd(input string tag, input int budget);
    for (int i = 0; i < budget && !mem_rd; i++) step();
    chk(tag, mem_rd, 1'b1);
  endtask

  task automatic wait_sc(input string tag, input logic [1:0] code, input int budget);
    for (int i = 0; i < budget && sc != code; i++) step();
    chk(tag, sc, code);
  endtask

  task automatic wait_int(input string tag, input int budget);
    for (int i = 0; i < budget && !int_ack; i++) step();
    chk(tag, int_ack, 1'b1);
  endtask

  // memory model: acks a pending read after a (possibly random) number of clks
  initial begin
    int wait_n;
    wait_n     = 0;
    mem_ack    = 1'b0;
    mem_data   = 8'h00;
    clk_enable = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      clk_enable = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_ack    = 1'b0;
      mem_data   = 8'($urandom);
      if (mem_rd && ack_en) begin
        if (wait_n == 0) begin
          mem_ack  = 1'b1;
          mem_data = mem[mem_addr];
          wait_n   = ack_rand ? $urandom_range(0, 3) : 0;
        end else begin
          wait_n--;
        end
      end
    end
  end

  // scoreboard: every delivered byte is mem[R0] with R0 advancing by one per byte
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset_n) begin
        if (data_valid) begin
          chk("dv_addr", mem_addr, exp_addr);
          chk("dv_data", data_out, mem[exp_addr]);
          chk("dv_no_int", int_ack, 1'b0);
          exp_addr = exp_addr + 16'd1;
          dv_total++;
          run_len++;
          chk("burst_le_8", run_len <= 8, 1'b1);
        end
        if (int_ack) begin
          int_total++;
          chk("int_sc", sc, 2'b11);
        end
        if (sc == 2'b00 || sc == 2'b01) run_len = 0;
        if (mem_rd) begin
          chk("rd_sc", sc, 2'b10);
          chk("rd_stall", cpu_stall, 1'b1);
        end
      end
    end
  end

  initial begin
    n_checks = 0; n_pass = 0; dv_total = 0; int_total = 0; run_len = 0;
    exp_addr = 16'h0900;
    ack_en = 1'b1; ack_rand = 1'b0; ce_rand = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    reset_n = 1'b1; cycle_boundary = 1'b1; dma_out_n = 1'b0;
    int_req = 1'b0; ie = 1'b0; r0_we = 1'b0; r0_wdata = 16'h0000;
    #2 reset_n = 1'b0;
    step(); step();

    // reset values
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_dv", data_valid, 1'b0);
    chk("rst_sc", sc, 2'b00);
    chk("rst_stall", cpu_stall, 1'b0);
    chk("rst_int_ack", int_ack, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    chk("rst_r0", r0, 16'h0900);

    // full row burst out of reset, then one forced execute slot
    reset_n = 1'b1;
    step();
    wait_sc("burst_end_exec", 2'b01, 200);
    chk("burst_dv_count", dv_total, 8);
    chk("burst_r0", r0, 16'h0908);
    chk("burst_last_addr", mem_addr, 16'h0907);
    chk("burst_end_stall", cpu_stall, 1'b0);
    step();
    chk("forced_slot_sc", sc, 2'b00);
    chk("forced_slot_stall", cpu_stall, 1'b0);
    dma_out_n = 1'b1;
    step(); step();

    // plain interrupt acknowledge
    int_req = 1'b1; ie = 1'b1;
    ibase = int_total;
    wait_int("int_seen", 20);
    chk("int_stall", cpu_stall, 1'b1);
    int_req = 1'b0;
    step();
    chk("int_pulse_end", int_ack, 1'b0);
    chk("int_stall_end", cpu_stall, 1'b0);
    chk("int_sc_end", sc, 2'b00);
    step(); step();
    chk("int_once", int_total - ibase, 1);

    // DMA beats interrupt; interrupt only after the burst returns to idle
    base = dv_total;
    dma_out_n = 1'b0; int_req = 1'b1;
    wait_int("int_after_dma", 200);
    chk("dma_first_count", dv_total - base, 8);
    int_req = 1'b0; dma_out_n = 1'b1;
    step(); step();

    // R0 load to FFFF then one fetch wraps; a write during the fetch is ignored
    r0_we = 1'b1; r0_wdata = 16'hFFFF;
    exp_addr = 16'hFFFF;
    step();
    r0_we = 1'b0;
    chk("r0_load", r0, 16'hFFFF);
    base = dv_total;
    dma_out_n = 1'b0;
    wait_rd("wrap_rd", 20);
    dma_out_n = 1'b1;
    r0_we = 1'b1; r0_wdata = 16'h1234;
    wait_sc("wrap_exec", 2'b01, 50);
    r0_we = 1'b0;
    chk("wrap_addr", mem_addr, 16'hFFFF);
    chk("wrap_r0", r0, 16'h0000);
    chk("wrap_dv", dv_total - base, 1);
    step(); step();

    // ack timeout aborts after 15 ticks
    ack_en = 1'b0;
    base = dv_total;
    dma_out_n = 1'b0;
    wait_rd("to_rd", 20);
    dma_out_n = 1'b1;
    n = 1;
    for (int i = 0; i < 100 && mem_rd; i++) begin
      step();
      if (mem_rd) n++;
    end
    chk("to_rd_ticks", n, 15);
    chk("to_bus_err", bus_err, 1'b1);
    chk("to_no_dv", dv_total - base, 0);
    chk("to_r0", r0, 16'h0000);
    step(); step();
    chk("to_idle_sc", sc, 2'b00);
    chk("to_idle_stall", cpu_stall, 1'b0);
    ack_en = 1'b1;

    // reset pulsed while waiting for memory
    ack_en = 1'b0;
    dma_out_n = 1'b0;
    wait_rd("mid_rst_rd", 20);
    base = dv_total;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd", mem_rd, 1'b0);
    chk("mid_rst_stall", cpu_stall, 1'b0);
    chk("mid_rst_r0", r0, 16'h0900);
    chk("mid_rst_bus_err", bus_err, 1'b0);
    exp_addr = 16'h0900;
    dma_out_n = 1'b1; ack_en = 1'b1;
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("mid_rst_no_dv", dv_total - base, 0);

    // randomized traffic against the scoreboard
    ce_rand = 1'b1; ack_rand = 1'b1;
    base = dv_total; ibase = int_total;
    for (int i = 0; i < 3000; i++) begin
      dma_out_n      = ($urandom_range(0, 3) == 0);
      int_req        = ($urandom_range(0, 3) == 0);
      ie             = $urandom_range(0, 1);
      cycle_boundary = ($urandom_range(0, 3) != 0);
      r0_we          = ($urandom_range(0, 7) == 0);
      r0_wdata       = 16'($urandom);
      if (r0_we && !cpu_stall) exp_addr = r0_wdata;
      step();
    end
    dma_out_n = 1'b1; int_req = 1'b0; r0_we = 1'b0; ce_rand = 1'b0;
    for (int i = 0; i < 100 && cpu_stall; i++) step();
    step(); step();
    chk("rand_idle", cpu_stall, 1'b0);
    chk("rand_r0", r0, exp_addr);
    chk("rand_bus_err", bus_err, 1'b0);
    chk("rand_dv_seen", dv_total - base > 0, 1'b1);
    chk("rand_int_seen", int_total - ibase > 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pixie_dma_out_responder.md
Name: pixie_dma_out_responder

Overview:
CPU-side servicer for the video generator's DMA-out requests and interrupt line. It lives in the CDP1802 bus clock domain next to the core.
- Arbitrates at machine-cycle boundaries between DMA-out, interrupt and normal execution.
- For each DMA-out grant, fetches mem[R0], hands the byte to the video block, post-increments R0 and drives the state code.
- Stalls the core while a DMA or interrupt-acknowledge cycle is in progress.

Parameters:
R0_RESET, 16'h0900, R0 value after reset; Studio II display page.
BURST_MAX, 8, DMA cycles per request burst before a forced execute slot (bytes per display row).
ACK_TIMEOUT, 15, clk_enable ticks to wait for mem_ack before aborting the cycle.

Ports:
clk  in  1  bus clock; all logic rises on posedge clk.
reset_n  in  1  asynchronous, active-low reset.
clk_enable  in  1  machine-cycle tick qualifier; state advances only when high.
cycle_boundary  in  1  core is at an S0/S1 boundary; arbitration permitted.
dma_out_n  in  1  DMA-out request, active-low (from video block DMAO).
int_req  in  1  interrupt request, active-high (from video block INT).
ie  in  1  core interrupt-enable flag.
r0_we  in  1  core writes R0 (PLO/PHI/LDA path).
r0_wdata  in  16  value for R0 write.
mem_addr  out  16  bus address during DMA.
mem_rd  out  1  read strobe, held until mem_ack.
mem_ack  in  1  memory data valid.
mem_data  in  8  memory read data.
data_out  out  8  byte to video block (its data_in).
data_valid  out  1  one-clk pulse, data_out valid.
SC  out  2  state code: 00 fetch, 01 execute, 10 DMA, 11 interrupt.
cpu_stall  out  1  hold core pipeline.
int_ack  out  1  one-clk pulse; core saves X,P into T, sets P=1,X=2, clears IE.
r0  out  16  current R0.
bus_err  out  1  sticky; set on ack timeout, cleared by reset only.

Behaviour:
- Reset (async, reset_n low) drives:
  - outputs: mem_addr=0, mem_rd=0, data_out=0, data_valid=0, SC=00, cpu_stall=0, int_ack=0, bus_err=0;
  - internal: r0=R0_RESET, state=IDLE, burst_cnt=0, timeout_cnt=0.
- FSM (all transitions gated by clk_enable except the mem_ack sampling, which is every clk):
  - IDLE: SC follows the core (00/01 passthrough not required; drive 00). On clk_enable && cycle_boundary:
    - if dma_out_n==0 and burst_cnt<BURST_MAX -> DMA_REQ;
    - else if int_req && ie -> INT_ACK;
    - else stay. Whenever IDLE takes no DMA grant, burst_cnt clears.
    - DMA has priority over interrupt when both are pending on the same boundary.
  - DMA_REQ: SC=10, cpu_stall=1, mem_addr=r0, mem_rd=1, timeout_cnt=0 -> DMA_WAIT.
  - DMA_WAIT: hold mem_rd. On the first clk with mem_ack=1: latch data_out=mem_data, pulse data_valid, mem_rd=0, r0<=r0+1 (16-bit wrap, FFFF->0000), burst_cnt++ -> DMA_END. Each clk_enable without ack: timeout_cnt++; at ACK_TIMEOUT: bus_err=1, mem_rd=0, r0 not incremented, no data_valid -> DMA_END.
  - DMA_END: on clk_enable:
    - if dma_out_n==0 and burst_cnt<BURST_MAX -> DMA_REQ (back-to-back, stall held);
    - else cpu_stall=0, SC=01 for one tick -> IDLE.
  - INT_ACK: SC=11, cpu_stall=1, int_ack pulse on entry clk; after one clk_enable -> IDLE, cpu_stall=0.
- Latency: DMA_REQ to data_valid = 1 clk after mem_ack. Minimum DMA cycle is 3 clk_enable ticks.
- r0_we:
  - while IDLE: r0<=r0_wdata;
  - during any DMA state: ignored (DMA owns R0);
  - on the same clk as a DMA increment: the increment wins.
- dma_out_n deasserting mid-cycle does not abort the cycle; only the next grant is affected.
- int_req arriving during a DMA burst is deferred until IDLE. int_ack never coincides with data_valid.
- Reset mid-burst: immediate return to reset values; the partially fetched byte is discarded.

Decomposition:
- Shared package pixie_pkg:
  - SC code constants (SC_FETCH, SC_EXEC, SC_DMA, SC_INT);
  - FSM state enum;
  - STUDIO2_VRAM_BASE=16'h0900;
  - BYTES_PER_ROW=8.
- One natural sub-module, pixie_r0_counter: 16-bit R0 with load and increment, and increment-over-load priority.

Test Plan:
- Reset with R0_RESET=0900 and dma_out_n low, then release -> 8 back-to-back DMA cycles. mem_addr 0900..0907, SC=10 throughout, data_valid x8, r0=0908, then SC=01 for one tick.
- int_req=1, ie=1, dma_out_n=1 at a boundary -> SC=11, int_ack pulses once, cpu_stall for exactly one clk_enable.
- dma_out_n=0 and int_req=1 on the same boundary -> DMA burst first, int_ack only after IDLE returns; int_ack never overlaps data_valid.
- r0_we with 16'hFFFF, then one DMA -> mem_addr=FFFF, r0 wraps to 0000.
- mem_ack withheld for 15 ticks -> bus_err=1, no data_valid, r0 unchanged, FSM back in IDLE.
- reset_n pulsed low in DMA_WAIT -> mem_rd=0, cpu_stall=0, r0=0900 asynchronously; no data_valid pulse follows.
